// File: rtl/puf_crp_controller.sv
// ----------------------------------------------------------------------------
// puf_crp_controller
//
// Initiator side of the XOR arbiter PUF array. For each request it walks an
// 8-bit LFSR challenge sequence. For every challenge it:
//   - resets the arbiter latches,
//   - launches the race edge,
//   - waits for the chains to settle,
//   - samples the XOR of the NUM_PUF synchronised arbiter responses.
// The resulting bits are shifted into a RESP_BITS-wide word. The finished
// word is handed to the host through a valid/ready handshake.
//
// Optional build macro: PUF_MAJ_VOTE_EN
//   When defined, every challenge is evaluated three times and the majority
//   of the three XOR samples is shifted in. The challenge advances only after
//   the third evaluation.
// ----------------------------------------------------------------------------
module puf_crp_controller #(
    parameter int RESP_BITS  = 16,
    parameter int NUM_PUF    = 3,
    parameter int RST_CYC    = 2,
    parameter int SETTLE_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           seed,
    output logic                 busy,
    output logic [7:0]           CH,
    output logic                 mux_in,
    output logic                 puf_rst,
    input  logic [NUM_PUF-1:0]   RESP,
    output logic [RESP_BITS-1:0] resp_word,
    output logic                 resp_valid,
    input  logic                 resp_ready
);

    // Wait counter must cover the longer of the two timed phases.
    localparam int CYC_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int CW      = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX + 1);
    localparam int BW      = $clog2(RESP_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Combine the raw arbiter responses into one PUF bit (XOR-arbiter construction).
    function automatic logic resp_bit_f(input logic [NUM_PUF-1:0] v);
        return ^v;
    endfunction

    // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR used for challenges.
    function automatic logic [7:0] lfsr_next_f(input logic [7:0] c);
        return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    endfunction

`ifdef PUF_MAJ_VOTE_EN
    // Two-out-of-three majority used to vote the repeated evaluations.
    function automatic logic maj3_f(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    state_t                 state_r;
    logic [7:0]             ch_r;
    logic                   mux_in_r;
    logic                   puf_rst_r;
    logic                   busy_r;
    logic                   resp_valid_r;
    logic [RESP_BITS-1:0]   resp_word_r;
    logic [CW-1:0]          cyc_cnt_r;
    logic [BW-1:0]          bit_cnt_r;
    logic [NUM_PUF-1:0]     resp_meta_r;
    logic [NUM_PUF-1:0]     resp_sync_r;
    logic                   sample_bit_s;
`ifdef PUF_MAJ_VOTE_EN
    logic [1:0]             eval_cnt_r;
    logic [1:0]             votes_r;
`endif

    assign sample_bit_s = resp_bit_f(resp_sync_r);

    assign busy       = busy_r;
    assign CH         = ch_r;
    assign mux_in     = mux_in_r;
    assign puf_rst    = puf_rst_r;
    assign resp_word  = resp_word_r;
    assign resp_valid = resp_valid_r;

    // Two-flop synchroniser for the asynchronous arbiter outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_meta_r <= {NUM_PUF{1'b0}};
            resp_sync_r <= {NUM_PUF{1'b0}};
        end else begin
            resp_meta_r <= RESP;
            resp_sync_r <= resp_meta_r;
        end
    end

    // Challenge/response sequencer with registered arbiter and host outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ch_r         <= 8'h00;
            mux_in_r     <= 1'b0;
            puf_rst_r    <= 1'b1;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_word_r  <= {RESP_BITS{1'b0}};
            cyc_cnt_r    <= {CW{1'b0}};
            bit_cnt_r    <= {BW{1'b0}};
`ifdef PUF_MAJ_VOTE_EN
            eval_cnt_r   <= 2'd0;
            votes_r      <= 2'b00;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    puf_rst_r    <= 1'b1;
                    mux_in_r     <= 1'b0;
                    resp_valid_r <= 1'b0;
                    if (start) begin
                        // An all-zero seed would lock the LFSR, so substitute 1.
                        ch_r        <= (seed == 8'h00) ? 8'h01 : seed;
                        bit_cnt_r   <= {BW{1'b0}};
                        cyc_cnt_r   <= {CW{1'b0}};
                        resp_word_r <= {RESP_BITS{1'b0}};
                        busy_r      <= 1'b1;
`ifdef PUF_MAJ_VOTE_EN
                        eval_cnt_r  <= 2'd0;
                        votes_r     <= 2'b00;
`endif
                        state_r     <= ST_ARM;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end

                ST_ARM: begin
                    // Hold the arbiter latches in reset before the race.
                    if (cyc_cnt_r == CW'(RST_CYC - 1)) begin
                        cyc_cnt_r <= {CW{1'b0}};
                        puf_rst_r <= 1'b0;
                        mux_in_r  <= 1'b1;
                        state_r   <= ST_LAUNCH;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CW'(1);
                        puf_rst_r <= 1'b1;
                        mux_in_r  <= 1'b0;
                        state_r   <= ST_ARM;
                    end
                end

                ST_LAUNCH: begin
                    puf_rst_r <= 1'b0;
                    mux_in_r  <= 1'b1;
                    cyc_cnt_r <= {CW{1'b0}};
                    state_r   <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    // Keep the race edge applied while the chains settle.
                    puf_rst_r <= 1'b0;
                    mux_in_r  <= 1'b1;
                    if (cyc_cnt_r == CW'(SETTLE_CYC - 1)) begin
                        cyc_cnt_r <= {CW{1'b0}};
                        state_r   <= ST_SAMPLE;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CW'(1);
                        state_r   <= ST_SETTLE;
                    end
                end

                ST_SAMPLE: begin
                    // Leaving SAMPLE always re-arms; CH only moves on this edge,
                    // together with mux_in falling.
                    puf_rst_r <= 1'b1;
                    mux_in_r  <= 1'b0;
                    cyc_cnt_r <= {CW{1'b0}};
`ifdef PUF_MAJ_VOTE_EN
                    if (eval_cnt_r == 2'd2) begin
                        resp_word_r <= {resp_word_r[RESP_BITS-2:0],
                                        maj3_f(votes_r[0], votes_r[1], sample_bit_s)};
                        ch_r        <= lfsr_next_f(ch_r);
                        bit_cnt_r   <= bit_cnt_r + BW'(1);
                        eval_cnt_r  <= 2'd0;
                        if (bit_cnt_r == BW'(RESP_BITS - 1)) begin
                            resp_valid_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            state_r <= ST_ARM;
                        end
                    end else begin
                        votes_r[eval_cnt_r[0]] <= sample_bit_s;
                        eval_cnt_r             <= eval_cnt_r + 2'd1;
                        state_r                <= ST_ARM;
                    end
`else
                    resp_word_r <= {resp_word_r[RESP_BITS-2:0], sample_bit_s};
                    ch_r        <= lfsr_next_f(ch_r);
                    bit_cnt_r   <= bit_cnt_r + BW'(1);
                    if (bit_cnt_r == BW'(RESP_BITS - 1)) begin
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        state_r <= ST_ARM;
                    end
`endif
                end

                ST_DONE: begin
                    // Word and challenge are frozen until the host takes the word.
                    puf_rst_r <= 1'b1;
                    mux_in_r  <= 1'b0;
                    if (resp_valid_r && resp_ready) begin
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        resp_valid_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_DONE;
                    end
                end

                default: begin
                    // Illegal encoding: fall back to the safe idle condition.
                    state_r      <= ST_IDLE;
                    puf_rst_r    <= 1'b1;
                    mux_in_r     <= 1'b0;
                    busy_r       <= 1'b0;
                    resp_valid_r <= 1'b0;
                    cyc_cnt_r    <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_controller.sv
// ----------------------------------------------------------------------------
// Bench for puf_crp_controller.
//
// The stimulus process fills a table of RESP values (one entry per arbiter
// evaluation) and computes from it, with plain arithmetic:
//   - the expected response word,
//   - the expected challenge sequence.
// It pushes both into queues. A negedge monitor:
//   - pops and compares them whenever the DUT launches a race or raises
//     resp_valid,
//   - checks latency, challenge stability and word hold.
// Honors PUF_MAJ_VOTE_EN.
// ----------------------------------------------------------------------------
module tb_puf_crp_controller;

    localparam int RB = 16;
    localparam int NP = 3;
    localparam int RC = 2;
    localparam int SC = 8;
`ifdef PUF_MAJ_VOTE_EN
    localparam int VOTES = 3;
`else
    localparam int VOTES = 1;
`endif
    localparam int EVALS = RB * VOTES;
    localparam int LAT   = EVALS * (RC + SC + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic          busy;
    logic [7:0]    CH;
    logic          mux_in;
    logic          puf_rst;
    logic [NP-1:0] RESP = '0;
    logic [RB-1:0] resp_word;
    logic          resp_valid;
    logic          resp_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NP-1:0] vals [0:EVALS-1];
    logic [RB-1:0] exp_word_q [$];
    logic [7:0]    exp_ch_q   [$];

    puf_crp_controller #(
        .RESP_BITS(RB), .NUM_PUF(NP), .RST_CYC(RC), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .busy(busy),
        .CH(CH), .mux_in(mux_in), .puf_rst(puf_rst), .RESP(RESP),
        .resp_word(resp_word), .resp_valid(resp_valid), .resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the challenge after c in the x^8+x^6+x^5+x^4+1 sequence.
    function automatic logic [7:0] next_challenge(input logic [7:0] c);
        logic fb;
        fb = c[7] ^ c[5] ^ c[4] ^ c[3];
        return ((c << 1) & 8'hFE) | {7'd0, fb};
    endfunction

    // Reference word: per challenge, count evaluations whose RESP has odd
    // parity, take the majority, shift in MSB-first.
    function automatic logic [RB-1:0] model_word();
        logic [RB-1:0] w;
        int ones;
        w = '0;
        for (int b = 0; b < RB; b++) begin
            ones = 0;
            for (int v = 0; v < VOTES; v++) ones += int'(^vals[b*VOTES + v]);
            w = {w[RB-2:0], (2 * ones > VOTES)};
        end
        return w;
    endfunction

    // Monitor: compares DUT outputs against the queued expectations.
    int         since = -2;
    int         hi_cnt = 0;
    bit         mux_prev = 1'b0;
    bit         valid_prev = 1'b0;
    logic [7:0] ch_prev = 8'h00;
    logic [RB-1:0] word_prev = '0;
    always @(negedge clk) begin
        logic [7:0]    e_ch;
        logic [RB-1:0] e_w;
        if (rst) begin
            since = -2; hi_cnt = 0; mux_prev = 1'b0; valid_prev = 1'b0;
        end else begin
            if (since >= -1) since++;
            if (mux_in && !mux_prev) begin
                chk(hi_cnt == RC, "arm_cycles", hi_cnt, RC);
                chk(!puf_rst, "puf_rst_at_launch", puf_rst, 0);
                chk(exp_ch_q.size() != 0, "ch_unexpected_launch", CH, 0);
                if (exp_ch_q.size() != 0) begin
                    e_ch = exp_ch_q.pop_front();
                    chk(CH == e_ch, "ch_seq", CH, e_ch);
                end
            end
            if (mux_in && mux_prev) chk(CH == ch_prev, "ch_stable_race", CH, ch_prev);
            if (busy && puf_rst && !mux_in) hi_cnt++; else hi_cnt = 0;
            if (since >= 0 && since < LAT) chk(busy && !resp_valid, "busy_run", {busy, resp_valid}, 2);
            if (resp_valid && !valid_prev) begin
                chk(since == LAT, "latency", since, LAT);
                chk(exp_word_q.size() != 0, "word_unexpected", resp_word, 0);
                if (exp_word_q.size() != 0) begin
                    e_w = exp_word_q.pop_front();
                    chk(resp_word == e_w, "resp_word", resp_word, e_w);
                end
                since = -2;
            end
            if (resp_valid && valid_prev) begin
                chk(resp_word == word_prev, "word_hold", resp_word, word_prev);
                chk(busy, "busy_done", busy, 1);
            end
            mux_prev = mux_in; valid_prev = resp_valid; ch_prev = CH; word_prev = resp_word;
            if (start && !busy) since = -1;
        end
    end

    task automatic fill_const(input logic [NP-1:0] v);
        for (int k = 0; k < EVALS; k++) vals[k] = v;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < EVALS; k++) vals[k] = NP'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        chk(CH == 8'h00, {tag, "_ch"}, CH, 0);
        chk(!mux_in, {tag, "_mux_in"}, mux_in, 0);
        chk(puf_rst, {tag, "_puf_rst"}, puf_rst, 1);
        chk(!busy, {tag, "_busy"}, busy, 0);
        chk(!resp_valid, {tag, "_valid"}, resp_valid, 0);
        chk(resp_word == '0, {tag, "_word"}, resp_word, 0);
    endtask

    // One request: expectations, start, per-evaluation RESP feed, optional
    // abort by reset, optional backpressure, then handshake.
    task automatic do_run(input logic [7:0] sd, input int abort_cyc, input int hold_cyc);
        logic [7:0]    ch;
        logic [RB-1:0] w;
        int i, c;
        bit mp;
        exp_word_q.push_back(model_word());
        ch = (sd == 8'h00) ? 8'h01 : sd;
        for (int b = 0; b < RB; b++) begin
            for (int v = 0; v < VOTES; v++) exp_ch_q.push_back(ch);
            ch = next_challenge(ch);
        end
        c = 0;
        while (busy && c < 50) begin @(posedge clk); #2; c++; end
        chk(!busy, "idle_before_start", busy, 0);
        RESP = vals[0]; seed = sd; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; seed = 8'($urandom);
        i = 0; mp = 1'b0;
        for (c = 0; c < LAT + 20 && i < EVALS; c++) begin
            if (abort_cyc > 0 && c == abort_cyc) begin
                #1 rst = 1'b1;
                #1 check_reset_values("abort");
                exp_word_q.delete(); exp_ch_q.delete();
                repeat (3) @(posedge clk);
                #2 rst = 1'b0;
                @(posedge clk); #2;
                chk(!resp_valid && !busy, "abort_no_valid", {busy, resp_valid}, 0);
                return;
            end
            if (mux_in && !mp) begin RESP = vals[i]; i++; end
            mp = mux_in;
            @(posedge clk); #2;
        end
        chk(i == EVALS, "feed_launch_count", i, EVALS);
        c = 0;
        while (!resp_valid && c < LAT) begin @(posedge clk); #2; c++; end
        chk(resp_valid, "valid_timeout", resp_valid, 1);
        resp_ready = 1'b0;
        for (int k = 0; k < hold_cyc; k++) begin
            start = 1'($urandom); seed = 8'($urandom);
            @(posedge clk); #2;
        end
        start = 1'b0;
        if (hold_cyc > 0) chk(resp_valid && busy, "no_restart_in_done", {busy, resp_valid}, 3);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
        w = resp_word;
        resp_ready = 1'b1; start = 1'b1;
        @(posedge clk); #2;
        resp_ready = 1'b0; start = 1'b0;
        chk(!resp_valid, "valid_clear", resp_valid, 0);
        chk(!busy, "busy_clear", busy, 0);
        @(posedge clk); #2;
        chk(!busy, "no_restart_on_handshake", busy, 0);
        chk(resp_word == w, "word_kept_idle", resp_word, w);
    endtask

    initial begin
        #12;
        check_reset_values("reset");
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2;
        check_reset_values("post_reset");

        fill_const(3'b000); do_run(8'hA5, 0, 0);   // all zero -> 0000
        fill_const(3'b001); do_run(8'h3C, 0, 0);   // odd parity -> FFFF
        fill_const(3'b011); do_run(8'h5A, 0, 0);   // even parity -> 0000
        fill_rand();        do_run(8'h00, 0, 0);   // zero seed -> 01,02,04...
        fill_rand();        do_run(8'($urandom), 0, 50);  // backpressure
        fill_rand();        do_run(8'h77, 100, 0); // reset mid-run
        fill_rand();        do_run(8'h01, 0, 0);   // clean run after abort
        // Vote pattern: 001 on 1st/3rd evaluation, 000 on the 2nd.
        for (int k = 0; k < EVALS; k++) vals[k] = ((k % VOTES) == 1) ? 3'b000 : 3'b001;
        do_run(8'hC3, 0, 0);
        for (int r = 0; r < 6; r++) begin
            fill_rand();
            do_run(8'($urandom), 0, (r == 2) ? 7 : 0);
        end

        chk(exp_word_q.size() == 0, "words_left", exp_word_q.size(), 0);
        chk(exp_ch_q.size() == 0, "challenges_left", exp_ch_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
